// File: rtl/mskand_hpc_pkg.sv
// Shared sizing helpers for the masked AND (HPC-style) datapath.
// Randomness counts and the pair index are functions of the share count d.
package mskand_hpc_pkg;

   // Refresh randomness per lane: a single bit suffices for two shares.
   function automatic int nref(input int d);
      return (d == 2) ? 1 : d;
   endfunction

   function automatic int nmul(input int d);
      return (d * (d - 1)) / 2;
   endfunction

   function automatic int nrnd(input int d);
      return nref(d) + nmul(d);
   endfunction

   // Position of pair (i,j), i<j, in the lane's multiplication randomness.
   function automatic int pair_idx(input int d, input int i, input int j);
      return i * d - (i * (i + 1)) / 2 + (j - i - 1);
   endfunction

endpackage

// File: rtl/mskand_hpc_lane.sv
// One masked AND lane: refresh of b, registered cross products with
// pairwise randomness, then registered share-wise recombination.
module mskand_hpc_lane
   import mskand_hpc_pkg::*;
#(
   parameter int D = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic [D-1:0]       a,
   input  logic [D-1:0]       b,
   input  logic [nrnd(D)-1:0] rnd,
   output logic [D-1:0]       out
);

   localparam int NREF = nref(D);
   localparam int NMUL = nmul(D);

   logic [D-1:0]          b_ref;
   logic [D-1:0]          a_q;
   logic [D-1:0]          br_q;
   logic [NMUL-1:0]       rm_q;
   logic [D-1:0][D-1:0]   u_d;
   logic [D-1:0][D-1:0]   u_q;
   logic [D-1:0]          out_d;

   // Every refresh bit enters exactly two shares, so the refresh cancels.
   if (D == 2) begin : g_ref2
      assign b_ref = b ^ {D{rnd[0]}};
   end else begin : g_refn
      always_comb begin
         b_ref = '0;
         for (int i = 0; i < D; i++)
            b_ref[i] = b[i] ^ rnd[i] ^ rnd[(i + D - 1) % D];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q  <= '0;
         br_q <= '0;
         rm_q <= '0;
      end else if (en) begin
         a_q  <= a;
         br_q <= b_ref;
         rm_q <= rnd[NREF +: NMUL];
      end
   end

   // u_d[i][j] and u_d[j][i] share one mask, which cancels on recombination.
   always_comb begin
      u_d = '0;
      for (int i = 0; i < D; i++) begin
         for (int j = 0; j < D; j++) begin
            if (i == j)
               u_d[i][j] = a_q[i] & br_q[j];
            else if (i < j)
               u_d[i][j] = (a_q[i] & br_q[j]) ^ rm_q[pair_idx(D, i, j)];
            else
               u_d[i][j] = (a_q[i] & br_q[j]) ^ rm_q[pair_idx(D, j, i)];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         u_q <= '0;
      else if (en)
         u_q <= u_d;
   end

   always_comb begin
      out_d = '0;
      for (int i = 0; i < D; i++)
         out_d[i] = ^u_q[i];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         out <= '0;
      else if (en)
         out <= out_d;
   end

endmodule

// File: rtl/mskand_hpc_vec.sv
// W-lane masked AND with a three-stage pipeline, global enable,
// output-valid tracking and a saturating count of accepted operations.
module mskand_hpc_vec
   import mskand_hpc_pkg::*;
#(
   parameter int d     = 2,
   parameter int W     = 8,
   parameter int CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  in_valid,
   input  logic [W*d-1:0]        ina,
   input  logic [W*d-1:0]        inb,
   input  logic [W*nrnd(d)-1:0]  rnd,
   output logic [W*d-1:0]        out,
   output logic                  out_valid,
   output logic [CNT_W-1:0]      op_cnt
);

   localparam int NRND = nrnd(d);

   // Handshake: no backpressure. Any en=1 cycle with in_valid=1 is an accept;
   // out_valid rises exactly three en=1 edges later and holds while en=0.
   logic       accept;
   logic [2:0] vld;

   assign accept    = en & in_valid;
   assign out_valid = vld[2];

   for (genvar k = 0; k < W; k++) begin : g_lane
      mskand_hpc_lane #(
         .D(d)
      ) u_lane (
         .clk   (clk),
         .rst_n (rst_n),
         .en    (en),
         .a     (ina[k*d +: d]),
         .b     (inb[k*d +: d]),
         .rnd   (rnd[k*NRND +: NRND]),
         .out   (out[k*d +: d])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         vld <= '0;
      else if (en)
         vld <= {vld[1:0], in_valid};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         op_cnt <= '0;
      else if (accept && (op_cnt != {CNT_W{1'b1}}))
         op_cnt <= op_cnt + 1'b1;
   end

endmodule

// File: doc/mskand_hpc_vec.md
MSKAND_HPC_VEC -- requirements
Module: mskand_hpc_vec

Interface
REQ-001 SHALL have parameter d, default 2: number of shares, legal range 2..8.
REQ-002 SHALL have parameter W, default 8: number of independent masked AND lanes.
REQ-003 SHALL have parameter CNT_W, default 16: width of the accepted-operation counter.
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port en, input, 1 bit: global advance; 0 freezes every register.
REQ-007 SHALL have port in_valid, input, 1 bit: ina, inb and rnd are valid this cycle.
REQ-008 SHALL have port ina, input, W*d bits: lane k share i at bit k*d+i.
REQ-009 SHALL have port inb, input, W*d bits: same layout as ina.
REQ-010 SHALL have port rnd, input, W*NRND bits: fresh randomness, lane-major.
REQ-011 SHALL have port out, output, W*d bits: masked AND result, same layout as ina.
REQ-012 SHALL have port out_valid, output, 1 bit: out carries a result.
REQ-013 SHALL have port op_cnt, output, CNT_W bits: count of accepted operations.

Function
REQ-014 SHALL compute per lane: XOR of out shares = (XOR of ina shares) AND (XOR of inb shares).
REQ-015 SHALL size per-lane randomness as NRND = NREF + NMUL, where NREF = 1 if d=2, else d, and NMUL = d(d-1)/2; rnd[NREF-1:0] of a lane is the refresh part.
REQ-016 SHALL accept an operation when en=1 and in_valid=1.
REQ-017 SHALL sample ina, inb and all rnd bits in the accept cycle; no randomness is read later.
REQ-018 SHALL compute stage 1 (registered): b_r[i] = inb[i] ^ r[i] ^ r[(i-1) mod d] for d>=3; for d=2, b_r[0] = inb[0]^r, b_r[1] = inb[1]^r. ina SHALL be registered alongside b_r. Multiplication randomness SHALL be registered here as well.
REQ-019 SHALL compute stage 2 (registered): for each i≠j, u_ij = a_i&b_r_j ^ r_min(i,j),max(i,j), plus a_i&b_r_i; each product term is held in its own register.
REQ-020 SHALL compute stage 3 (registered): out_i = (a_i&b_r_i) XOR all u_ij over j≠i.
REQ-021 SHALL have a latency of exactly 3 advancing (en=1) cycles from accept to out_valid=1.
REQ-022 SHALL use a 3-bit valid shift register that advances only when en=1; out_valid is its last bit.
REQ-023 SHALL freeze all data, randomness, valid and counter registers while en=0; out and out_valid hold.
REQ-024 SHALL advance data stages on every en=1 cycle, including bubbles (in_valid=0); out content is unspecified while out_valid=0.
REQ-025 SHALL sustain back-to-back accepts with throughput 1 per cycle and no stall logic.
REQ-026 SHALL increment op_cnt by 1 on each accept and saturate at 2^CNT_W-1 with no wrap.
REQ-027 SHALL keep every share-domain combination registered before recombination, with no combinational path from input shares to out.

Reset
REQ-028 SHALL, on rst_n=0, asynchronously clear all pipeline registers, out, out_valid and op_cnt to 0.
REQ-029 SHALL discard operations in flight when reset asserts mid-operation; the first out_valid after release SHALL come 3 advancing cycles after the first new accept.

Structure
REQ-030 SHALL place the NREF, NMUL and NRND functions of d in a shared package, used by the module and the bench.
REQ-031 SHALL implement one lane as sub-module mskand_hpc_lane, replicated W times; valid pipeline and op_cnt SHALL live in the top level.

Verification
REQ-032 SHALL cover, with d=2, W=1, ina shares (1,0), inb shares (1,1), r=1, mul rnd=0, en=1: out_valid at cycle 3 and out shares XOR to 0; then inb=(0,1): XOR to 1.
REQ-033 SHALL cover a stall: accept at t0, en=0 for cycles 1..4, en=1 afterwards: out_valid rises exactly on the 3rd en=1 edge, and out is unchanged during the stall.
REQ-034 SHALL cover back-to-back operation: 20 consecutive accepts with random d=3, W=8 data: 20 consecutive correct results, out_valid continuous, op_cnt=20.
REQ-035 SHALL cover reset mid-operation: rst_n low 1 cycle after 2 accepts: out_valid=0, op_cnt=0 immediately, and no stale result appears afterwards.
REQ-036 SHALL cover saturation: CNT_W=4 with 20 accepts: op_cnt stops at 15.
REQ-037 SHALL cover randomness sensitivity: the same inputs with different rnd change the out shares while their XOR is unchanged.
